fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-002 The module SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 The module SHALL have port Stall_En  input  1  hold PC (hazard stall from decode).
REQ-004 The module SHALL have port Redirect_En  input  1  execute-stage misprediction correction.
REQ-005 The module SHALL have port Redirect_PC  input  32  corrected fetch address.
REQ-006 The module SHALL have port Update_En  input  1  resolved branch/jump update to predictor.
REQ-007 The module SHALL have port Update_PC  input  32  PC of the resolved branch.
REQ-008 The module SHALL have port Update_Taken  input  1  resolved direction.
REQ-009 The module SHALL have port Update_Target  input  32  resolved taken target.
REQ-010 The module SHALL have port PC_F  output  32  current fetch address (also instruction-memory address).
REQ-011 The module SHALL have port PC_Plus_4_F  output  32  PC_F + 4.
REQ-012 The module SHALL have port Predict_Taken_F  output  1  prediction for the instruction at PC_F.

Function
REQ-013 The module SHALL hold PC_F in a 32-bit register; PC_Plus_4_F SHALL be combinational PC_F + 4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-014 The predictor SHALL be a 16-entry direct-mapped table; index PC[5:2], tag PC[31:6]; each entry: valid, 26-bit tag, 2-bit counter, 30-bit target (word-aligned, bits [1:0] = 00).
REQ-015 Lookup SHALL be combinational on PC_F: hit = valid AND tag match; Predict_Taken_F = hit AND counter >= 2.
REQ-016 Next-PC priority SHALL be: Redirect_En -> Redirect_PC; else Stall_En -> PC_F held; else Predict_Taken_F -> stored target; else PC_Plus_4_F.
REQ-017 Redirect_En SHALL override Stall_En in the same cycle.
REQ-018 On Update_En with hit on Update_PC: counter saturating increment if Update_Taken (max 3), else saturating decrement (min 0); target overwritten with Update_Target only when Update_Taken.
REQ-019 On Update_En with miss and Update_Taken: entry allocated (valid=1, tag, target, counter=2), replacing any prior occupant.
REQ-020 On Update_En with miss and not Update_Taken: table SHALL be unchanged.
REQ-021 Updates SHALL be applied regardless of Stall_En.
REQ-022 A lookup and an update to the same index in one cycle SHALL see pre-update contents (read-before-write); the new contents are visible from the next cycle.
REQ-023 Latency: next-PC selection SHALL take effect on PC_F one cycle after the controlling inputs.

Reset
REQ-024 While RST is high at a rising edge: PC_F <= 0x0000_0000, all valid bits <= 0, all counters <= 1 (weakly not-taken); Stall_En, Redirect_En, Update_En SHALL be ignored that cycle.
REQ-025 Consequently Predict_Taken_F SHALL be 0 and PC_Plus_4_F 0x0000_0004 in the first cycle after reset; reset mid-operation SHALL discard all predictor history in one cycle.

Configuration
REQ-026 Macro BRANCH_PREDICT_EN SHALL compile the predictor table in.
REQ-027 With BRANCH_PREDICT_EN defined: behaviour per REQ-014..REQ-022.
REQ-028 Without it: no table storage, Predict_Taken_F tied 0, Update_* inputs ignored, next PC = Redirect_PC, held PC or PC_Plus_4_F only.

Verification
REQ-029 Reset then 4 free cycles -> PC_F 0x0, 0x4, 0x8, 0xC; Predict_Taken_F 0 throughout.
REQ-030 Stall_En=1 at PC_F=0x8 for 3 cycles -> PC_F stays 0x8; then Stall_En=1 with Redirect_En=1, Redirect_PC=0x100 -> PC_F 0x100 next cycle.
REQ-031 Update_En, Update_PC=0x10, Taken=1, Target=0x40 -> later PC_F=0x10 gives Predict_Taken_F=1, next PC_F 0x40.
REQ-032 Two not-taken updates on 0x10 (counter 2->1->0) -> PC_F=0x10 predicts not-taken, next PC_F 0x14; three taken updates saturate at 3, fourth leaves 3.
REQ-033 Alias: entry at 0x10 allocated, then taken update PC=0x50 (same index 4) target 0x80 -> 0x10 misses, 0x50 predicts 0x80.
REQ-034 Update on 0x10 in the same cycle PC_F=0x10 (first allocation) -> Predict_Taken_F 0 that cycle, 1 on next visit; with BRANCH_PREDICT_EN undefined, repeat -> Predict_Taken_F always 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC select and optional 16-entry branch predictor.
// Define BRANCH_PREDICT_EN to build the predictor table in; without it the Update_* inputs are ignored.
module fetch_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall_En,
   input  logic        Redirect_En,
   input  logic [31:0] Redirect_PC,
   input  logic        Update_En,
   input  logic [31:0] Update_PC,
   input  logic        Update_Taken,
   input  logic [31:0] Update_Target,
   output logic [31:0] PC_F,
   output logic [31:0] PC_Plus_4_F,
   output logic        Predict_Taken_F
);

   logic [31:0] pred_target;
   logic [31:0] pc_next;

   assign PC_Plus_4_F = PC_F + 32'd4;

`ifdef BRANCH_PREDICT_EN
   typedef struct packed {
      logic        valid;
      logic [25:0] tag;
      logic [1:0]  ctr;
      logic [29:0] tgt;
   } bp_entry_t;

   bp_entry_t  bpt [16];
   logic [3:0] look_idx, upd_idx;
   logic       look_hit, upd_hit;
   logic       unused_lsbs;

   assign look_idx        = PC_F[5:2];
   assign upd_idx         = Update_PC[5:2];
   assign look_hit        = bpt[look_idx].valid && (bpt[look_idx].tag == PC_F[31:6]);
   assign upd_hit         = bpt[upd_idx].valid && (bpt[upd_idx].tag == Update_PC[31:6]);
   assign Predict_Taken_F = look_hit && bpt[look_idx].ctr[1];
   assign pred_target     = {bpt[look_idx].tgt, 2'b00};
   assign unused_lsbs     = ^{Update_PC[1:0], Update_Target[1:0]};

   // Lookup reads the registered table, so a same-cycle update is only seen next cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 16; i++) begin
            bpt[i].valid <= 1'b0;
            bpt[i].ctr   <= 2'd1;
         end
      end else if (Update_En) begin
         if (upd_hit) begin
            if (Update_Taken) begin
               bpt[upd_idx].ctr <= (bpt[upd_idx].ctr == 2'd3) ? 2'd3 : bpt[upd_idx].ctr + 2'd1;
               bpt[upd_idx].tgt <= Update_Target[31:2];
            end else begin
               bpt[upd_idx].ctr <= (bpt[upd_idx].ctr == 2'd0) ? 2'd0 : bpt[upd_idx].ctr - 2'd1;
            end
         end else if (Update_Taken) begin
            bpt[upd_idx] <= '{valid: 1'b1, tag: Update_PC[31:6], ctr: 2'd2,
                              tgt: Update_Target[31:2]};
         end
      end
   end
`else
   logic unused_upd;

   assign Predict_Taken_F = 1'b0;
   assign pred_target     = PC_Plus_4_F;
   assign unused_upd      = ^{Update_En, Update_PC, Update_Taken, Update_Target};
`endif

   always_comb begin
      pc_next = PC_Plus_4_F;
      if (Redirect_En)          pc_next = Redirect_PC;
      else if (Stall_En)        pc_next = PC_F;
      else if (Predict_Taken_F) pc_next = pred_target;
   end

   always_ff @(posedge CLK) begin
      if (RST) PC_F <= 32'h0;
      else     PC_F <= pc_next;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle model comparison plus hand-computed checkpoints.
module tb_fetch_unit;

`ifdef BRANCH_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        Stall_En = 1'b0, Redirect_En = 1'b0, Update_En = 1'b0, Update_Taken = 1'b0;
   logic [31:0] Redirect_PC = '0, Update_PC = '0, Update_Target = '0;
   logic [31:0] PC_F, PC_Plus_4_F;
   logic        Predict_Taken_F;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   fetch_unit dut (
      .CLK(CLK), .RST(RST), .Stall_En(Stall_En), .Redirect_En(Redirect_En),
      .Redirect_PC(Redirect_PC), .Update_En(Update_En), .Update_PC(Update_PC),
      .Update_Taken(Update_Taken), .Update_Target(Update_Target),
      .PC_F(PC_F), .PC_Plus_4_F(PC_Plus_4_F), .Predict_Taken_F(Predict_Taken_F)
   );

   always #5 CLK = ~CLK;

   // Predictor model: entries keyed by PC index, holding the last taken-allocated branch.
   logic [31:0] m_pc = '0;
   bit          m_v   [16];
   logic [31:0] m_br  [16];
   int          m_ctr [16];
   logic [31:0] m_tgt [16];

   function automatic bit m_hit(input logic [31:0] pc);
      int i = int'(pc[5:2]);
      return PRED_EN && m_v[i] && (m_br[i][31:6] == pc[31:6]);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[int'(pc[5:2])] >= 2);
   endfunction

   always @(posedge CLK) begin
      if (RST) begin
         m_pc = 32'h0;
         for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_ctr[i] = 1; end
      end else begin
         logic [31:0] nxt;
         int          ui;
         if (Redirect_En)     nxt = Redirect_PC;
         else if (Stall_En)   nxt = m_pc;
         else if (m_pred(m_pc)) nxt = m_tgt[int'(m_pc[5:2])];
         else                 nxt = m_pc + 32'd4;
         ui = int'(Update_PC[5:2]);
         if (PRED_EN && Update_En) begin
            if (m_hit(Update_PC)) begin
               if (Update_Taken) begin
                  m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                  m_tgt[ui] = {Update_Target[31:2], 2'b00};
               end else begin
                  m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
               end
            end else if (Update_Taken) begin
               m_v[ui] = 1'b1; m_br[ui] = Update_PC; m_ctr[ui] = 2;
               m_tgt[ui] = {Update_Target[31:2], 2'b00};
            end
         end
         m_pc = nxt;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("model PC_F", PC_F, m_pc);
         chk("model PC_Plus_4_F", PC_Plus_4_F, m_pc + 32'd4);
         chk("model Predict_Taken_F", {31'b0, Predict_Taken_F}, {31'b0, m_pred(m_pc)});
      end
   end

   // Applies one cycle of inputs at the falling edge; outputs seen on return belong to this cycle.
   task automatic drive(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit ue, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
      @(negedge CLK);
      RST = rst; Stall_En = st; Redirect_En = rd; Redirect_PC = rpc;
      Update_En = ue; Update_PC = upc; Update_Taken = ut; Update_Target = utg;
   endtask

   task automatic idle();               drive(0, 0, 0, 0, 0, 0, 0, 0);   endtask
   task automatic redir(input logic [31:0] a); drive(0, 0, 1, a, 0, 0, 0, 0); endtask
   task automatic upd(input logic [31:0] a, input bit t, input logic [31:0] g);
      drive(0, 0, 0, 0, 1, a, t, g);
   endtask

   task automatic lit(input string nm, input logic [31:0] pc, input bit pt);
      chk({nm, " PC_F"}, PC_F, pc);
      chk({nm, " Predict_Taken_F"}, {31'b0, Predict_Taken_F}, {31'b0, pt});
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk_en = 1'b1;
      // Free-running fetch out of reset
      idle(); lit("rst0", 32'h0, 0); chk("rst0 PC_Plus_4_F", PC_Plus_4_F, 32'h4);
      idle(); lit("free1", 32'h4, 0);
      idle(); lit("free2", 32'h8, 0);
      redir(32'h8); lit("free3", 32'hC, 0);
      // Stall three cycles, then redirect wins over stall
      drive(0, 1, 0, 0, 0, 0, 0, 0); lit("stall1", 32'h8, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0); lit("stall2", 32'h8, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0); lit("stall3", 32'h8, 0);
      drive(0, 1, 1, 32'h100, 0, 0, 0, 0); lit("stall+redir", 32'h8, 0);
      // Allocate 0x10 -> 0x40 while redirecting to it
      drive(0, 0, 1, 32'h10, 1, 32'h10, 1, 32'h40); lit("redir", 32'h100, 0);
      idle(); lit("alloc hit", 32'h10, PRED_EN);
      upd(32'h10, 0, 0); lit("alloc next", PRED_EN ? 32'h40 : 32'h14, 0);
      // Two not-taken updates: counter 2->1->0
      upd(32'h10, 0, 0);
      redir(32'h10);
      idle(); lit("weak nt", 32'h10, 0);
      idle(); lit("weak nt next", 32'h14, 0);
      // Saturate at 3 with four taken updates, then one not-taken leaves 2
      upd(32'h10, 1, 32'h60); upd(32'h10, 1, 32'h60);
      upd(32'h10, 1, 32'h60); upd(32'h10, 1, 32'h60);
      drive(0, 0, 1, 32'h10, 1, 32'h10, 0, 0);
      idle(); lit("sat", 32'h10, PRED_EN);
      idle(); lit("sat next", PRED_EN ? 32'h60 : 32'h14, 0);
      // Alias: 0x50 shares index 4 with 0x10 and replaces it
      upd(32'h50, 1, 32'h80);
      redir(32'h10);
      redir(32'h50); lit("alias old", 32'h10, 0);
      idle(); lit("alias new", 32'h50, PRED_EN);
      idle(); lit("alias next", PRED_EN ? 32'h80 : 32'h54, 0);
      // Mid-run reset with stall and a taken update asserted: both ignored
      drive(1, 1, 0, 0, 1, 32'h10, 1, 32'h40);
      idle(); lit("rst1", 32'h0, 0); chk("rst1 PC_Plus_4_F", PC_Plus_4_F, 32'h4);
      redir(32'h10); lit("rst1 free", 32'h4, 0);
      // Same-cycle update of the entry being looked up
      upd(32'h10, 1, 32'h40); lit("rbw same", 32'h10, 0);
      redir(32'h10); lit("rbw after", 32'h14, 0);
      redir(32'h50); lit("rbw revisit", 32'h10, PRED_EN);
      idle(); lit("history gone", 32'h50, 0);
      // Wrap-around of the PC adder
      redir(32'hFFFF_FFFC);
      idle(); lit("wrap", 32'hFFFF_FFFC, 0); chk("wrap PC_Plus_4_F", PC_Plus_4_F, 32'h0);
      idle(); lit("wrap next", 32'h0, 0);
      idle();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
